fp_denorm_to_fixed: RTL and testbench
=====================================

Name: fp_denorm_to_fixed

Overview:
- Inverse of the multiplier justification stage. Takes a justified float: 16-bit two's-complement Q1.15 mantissa plus 8-bit two's-complement exponent.
- Produces a rounded, saturated signed integer: round(ma × 2^(ea−15)).
- Iterative, 1 bit of shift per clock, with valid/ready handshakes on both sides.
- Sits between fp arithmetic outputs and fixed-point consumers, e.g. pixel/coefficient writeback.

Parameters:
- OUT_W, 16, output integer width in bits. Legal range 16..32.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input operand valid.
- in_ready  output  1  block can accept an operand; high only in IDLE.
- ma  input  16  justified mantissa, two's complement Q1.15.
- ea  input  8  exponent, two's complement.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- out_data  output  OUT_W  signed integer result.
- out_sat  output  1  result was saturated.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values (asynchronous): state=IDLE, in_ready=1, out_valid=0, out_data=0, out_sat=0, busy=0. Internal accumulator, guard and count are also cleared.
- Reset asserted mid-operation aborts the operand. No result is produced for it.
- States: IDLE, LSHIFT, RSHIFT, ROUND, DONE.
- Shift request: s = sign-extended ea − 15, computed in 9 bits.
- Shift count k:
  - ma==0: k=0.
  - s>0: k=min(s, OUT_W), left shift.
  - s<0: k=min(−s, 17), right shift.
  - s=0: k=0.
- IDLE, on in_valid & in_ready:
  - Load acc with ma sign-extended to OUT_W bits. Clear guard and out_sat.
  - Next state is LSHIFT or RSHIFT if k>0, else ROUND.
- RSHIFT, once per clock:
  - guard <= acc[0]; acc <= acc arithmetic-shifted right by 1; count decrements.
  - When count reaches 0, go to ROUND.
- LSHIFT, once per clock:
  - If acc[OUT_W−1] != acc[OUT_W−2], set sat and go to ROUND immediately. acc is not shifted.
  - Otherwise acc <= acc<<1 with zero fill; count decrements. When count reaches 0, go to ROUND.
- ROUND, one clock:
  - out_data <= sat ? (ma negative ? min signed : max signed) : acc + guard.
  - Rounding is half toward +infinity, i.e. +guard in two's complement. It cannot overflow, because a right shift of ≥1 halves the magnitude.
  - Then go to DONE.
- DONE: out_valid=1. out_data and out_sat stay stable until out_ready. On out_ready, go to IDLE.
  - in_ready stays low in DONE, so accept and complete never occur in the same clock.
- Latency: out_valid rises k+1 clocks after the accepting edge. An early saturation exit shortens this.
- Throughput: at most one operand per k+3 clocks.
- ea=0x80 (−128) clamps to 17 right shifts. The result is then 0 for all ma, including negative ma (−1 + guard 1 = 0).
- in_valid while busy is ignored; the operand must be held by the producer.
- ma and ea are sampled only at the accepting edge.

Test Plan:
- OUT_W=16, ma=0x4000, ea=15 -> out_data=0x4000, out_sat=0; out_valid 1 clock after accept.
- OUT_W=16, ma=0x4001, ea=14 -> out_data=0x2001. Same with ma=0xC001 -> out_data=0xE001 (−8191, half toward +inf); out_valid 2 clocks after accept.
- OUT_W=16, ma=0x4000, ea=0x80 -> out_data=0, out_valid 18 clocks after accept. Same with ma=0x0000, any ea -> out_data=0 after 1 clock.
- OUT_W=24:
  - ma=0x4000, ea=20 -> out_data=0x080000, sat=0, after 6 clocks.
  - ma=0x4000, ea=24 -> out_data=0x7FFFFF, out_sat=1.
  - OUT_W=16, ma=0xA000, ea=17 -> out_data=0x8000, out_sat=1.
- Backpressure: hold out_ready=0 for 5 clocks in DONE -> out_valid, out_data, out_sat stable and in_ready=0. Pulse out_ready -> IDLE next clock, in_ready=1.
- Reset mid-RSHIFT (ea=0x80, rst_n low at clock 5) -> all outputs at reset values immediately. After release, a new operand completes normally.

Source files
------------

// File: rtl/fp_denorm_to_fixed.sv
// Converts a justified float (Q1.15 mantissa, two's-complement exponent) into a
// rounded, saturated signed integer by shifting one bit per clock.
module fp_denorm_to_fixed #(
   parameter int OUT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      ma,
   input  logic [7:0]       ea,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_sat,
   output logic             busy
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LSHIFT = 3'd1;
   localparam logic [2:0] ST_RSHIFT = 3'd2;
   localparam logic [2:0] ST_ROUND  = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   localparam logic [8:0] OUT_W9  = 9'(OUT_W);
   localparam logic [8:0] RMAX9   = 9'd17;
   localparam logic [OUT_W-1:0] MAX_VAL = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] MIN_VAL = {1'b1, {(OUT_W-1){1'b0}}};

   logic [2:0]       state_reg;
   logic [OUT_W-1:0] acc_reg;
   logic             guard_reg;
   logic [5:0]       count_reg;
   logic             sat_reg;
   logic             neg_reg;
   logic [OUT_W-1:0] out_data_reg;
   logic             out_sat_reg;

   // Shift request and its clamped magnitude, evaluated on the operand inputs.
   logic [8:0]       shift_req;
   logic [8:0]       shift_mag;
   logic             shift_right;
   logic [5:0]       k_next;
   logic [OUT_W-1:0] acc_load;

   always_comb begin
      shift_req   = {ea[7], ea} - 9'd15;
      shift_right = shift_req[8];
      shift_mag   = shift_right ? (~shift_req + 9'd1) : shift_req;
      k_next      = 6'd0;
      if (ma != 16'd0 && shift_mag != 9'd0) begin
         if (shift_right)
            k_next = (shift_mag > RMAX9) ? 6'd17 : shift_mag[5:0];
         else
            k_next = (shift_mag > OUT_W9) ? OUT_W9[5:0] : shift_mag[5:0];
      end
      acc_load = OUT_W'($signed(ma));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         acc_reg      <= '0;
         guard_reg    <= 1'b0;
         count_reg    <= 6'd0;
         sat_reg      <= 1'b0;
         neg_reg      <= 1'b0;
         out_data_reg <= '0;
         out_sat_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (in_valid) begin
                  acc_reg     <= acc_load;
                  guard_reg   <= 1'b0;
                  sat_reg     <= 1'b0;
                  out_sat_reg <= 1'b0;
                  neg_reg     <= ma[15];
                  count_reg   <= k_next;
                  if (k_next == 6'd0)
                     state_reg <= ST_ROUND;
                  else if (shift_right)
                     state_reg <= ST_RSHIFT;
                  else
                     state_reg <= ST_LSHIFT;
               end
            end
            ST_RSHIFT: begin
               guard_reg <= acc_reg[0];
               acc_reg   <= {acc_reg[OUT_W-1], acc_reg[OUT_W-1:1]};
               count_reg <= count_reg - 6'd1;
               if (count_reg == 6'd1)
                  state_reg <= ST_ROUND;
            end
            ST_LSHIFT: begin
               // The next shift would change the sign bit: saturate instead.
               if (acc_reg[OUT_W-1] != acc_reg[OUT_W-2]) begin
                  sat_reg   <= 1'b1;
                  state_reg <= ST_ROUND;
               end else begin
                  acc_reg   <= {acc_reg[OUT_W-2:0], 1'b0};
                  count_reg <= count_reg - 6'd1;
                  if (count_reg == 6'd1)
                     state_reg <= ST_ROUND;
               end
            end
            ST_ROUND: begin
               if (sat_reg)
                  out_data_reg <= neg_reg ? MIN_VAL : MAX_VAL;
               else
                  out_data_reg <= acc_reg + OUT_W'(guard_reg);
               out_sat_reg <= sat_reg;
               state_reg   <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready)
                  state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_reg == ST_IDLE);
   assign busy      = (state_reg != ST_IDLE);
   assign out_valid = (state_reg == ST_DONE);
   assign out_data  = out_data_reg;
   assign out_sat   = out_sat_reg;

endmodule

// File: tb/tb_fp_denorm_to_fixed.sv
// Directed-vector bench for fp_denorm_to_fixed at OUT_W=16 and OUT_W=24.
module tb_fp_denorm_to_fixed;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] ma = 16'd0;
   logic [7:0]  ea = 8'd0;

   logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b0, os16, bz16;
   logic [15:0] od16;
   logic        iv24 = 1'b0, ir24, ov24, or24 = 1'b0, os24, bz24;
   logic [23:0] od24;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fp_denorm_to_fixed #(.OUT_W(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
      .ma(ma), .ea(ea), .out_valid(ov16), .out_ready(or16),
      .out_data(od16), .out_sat(os16), .busy(bz16)
   );

   fp_denorm_to_fixed #(.OUT_W(24)) dut24 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv24), .in_ready(ir24),
      .ma(ma), .ea(ea), .out_valid(ov24), .out_ready(or24),
      .out_data(od24), .out_sat(os24), .busy(bz24)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, act);
      end
   endtask

   // Issue one operand, wait for the result, check it, then accept it.
   task automatic run_vec(input string tag, input int w, input logic [15:0] m,
                          input logic [7:0] e, input logic [31:0] exp_data,
                          input logic exp_sat, input int exp_lat);
      int cyc;
      ma = m;
      ea = e;
      if (w == 16) iv16 = 1'b1; else iv24 = 1'b1;
      @(posedge clk); #1;
      iv16 = 1'b0;
      iv24 = 1'b0;
      cyc = 0;
      while (!(w == 16 ? ov16 : ov24) && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_eq({tag, " lat"}, 32'(cyc), 32'(exp_lat));
      check_eq({tag, " data"}, (w == 16) ? {16'd0, od16} : {8'd0, od24}, exp_data);
      check_eq({tag, " sat"}, {31'd0, (w == 16) ? os16 : os24}, {31'd0, exp_sat});
      if (w == 16) or16 = 1'b1; else or24 = 1'b1;
      @(posedge clk); #1;
      or16 = 1'b0;
      or24 = 1'b0;
      check_eq({tag, " in_ready after"}, {31'd0, (w == 16) ? ir16 : ir24}, 32'd1);
      check_eq({tag, " out_valid after"}, {31'd0, (w == 16) ? ov16 : ov24}, 32'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst in_ready", {31'd0, ir16}, 32'd1);
      check_eq("rst out_valid", {31'd0, ov16}, 32'd0);
      check_eq("rst busy", {31'd0, bz16}, 32'd0);
      check_eq("rst out_data", {16'd0, od16}, 32'd0);
      check_eq("rst out_sat", {31'd0, os16}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_vec("w16 unity",      16, 16'h4000, 8'd15,  32'h00004000, 1'b0, 1);
      run_vec("w16 rsh1 pos",   16, 16'h4001, 8'd14,  32'h00002001, 1'b0, 2);
      run_vec("w16 rsh1 neg",   16, 16'hC001, 8'd14,  32'h0000E001, 1'b0, 2);
      run_vec("w16 ea min pos", 16, 16'h4000, 8'h80,  32'h00000000, 1'b0, 18);
      run_vec("w16 ea min neg", 16, 16'h8000, 8'h80,  32'h00000000, 1'b0, 18);
      run_vec("w16 ma zero",    16, 16'h0000, 8'd50,  32'h00000000, 1'b0, 1);
      run_vec("w16 sat neg",    16, 16'hA000, 8'd17,  32'h00008000, 1'b1, 2);
      run_vec("w16 lsh neg ok", 16, 16'hC000, 8'd16,  32'h00008000, 1'b0, 2);
      run_vec("w16 sat clamp",  16, 16'h0001, 8'd127, 32'h00007FFF, 1'b1, 16);
      run_vec("w24 lsh5",       24, 16'h4000, 8'd20,  32'h00080000, 1'b0, 6);
      run_vec("w24 sat pos",    24, 16'h4000, 8'd24,  32'h007FFFFF, 1'b1, 10);
      run_vec("w24 min exact",  24, 16'h8000, 8'd23,  32'h00800000, 1'b0, 9);

      // Backpressure: result must hold while the consumer stalls.
      ma = 16'h4000;
      ea = 8'd15;
      iv16 = 1'b1;
      @(posedge clk); #1;
      iv16 = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         check_eq($sformatf("bp%0d out_valid", i), {31'd0, ov16}, 32'd1);
         check_eq($sformatf("bp%0d data", i), {16'd0, od16}, 32'h00004000);
         check_eq($sformatf("bp%0d sat", i), {31'd0, os16}, 32'd0);
         check_eq($sformatf("bp%0d in_ready", i), {31'd0, ir16}, 32'd0);
         @(posedge clk); #1;
      end
      or16 = 1'b1;
      @(posedge clk); #1;
      or16 = 1'b0;
      check_eq("bp release in_ready", {31'd0, ir16}, 32'd1);
      check_eq("bp release out_valid", {31'd0, ov16}, 32'd0);

      // Reset in the middle of a long right shift.
      ma = 16'h4000;
      ea = 8'h80;
      iv16 = 1'b1;
      @(posedge clk); #1;
      iv16 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check_eq("mid busy", {31'd0, bz16}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("abort in_ready", {31'd0, ir16}, 32'd1);
      check_eq("abort out_valid", {31'd0, ov16}, 32'd0);
      check_eq("abort busy", {31'd0, bz16}, 32'd0);
      check_eq("abort out_data", {16'd0, od16}, 32'd0);
      check_eq("abort out_sat", {31'd0, os16}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_vec("post rst",       16, 16'h4001, 8'd14,  32'h00002001, 1'b0, 2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
